// File: rtl/err_det_pkg.sv
// Shared constants and helpers for the multi-channel fault qualifier.
//   CH_DEF / CNT_W_DEF / REC_TICKS_DEF : default parameter values
//   clog2_min1(n)                      : index width for n items, never below 1
package err_det_pkg;

    localparam int CH_DEF        = 8;
    localparam int CNT_W_DEF     = 14;
    localparam int REC_TICKS_DEF = 4;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/err_det_chan.sv
// One fault channel: input synchroniser, polarity normalisation, qualify
// counter, recovery counter and the fault flag.
//   clk, rst    : clock, async active-high reset
//   strobe      : 1-cycle 1 us tick from the top level
//   reset_unit  : global clear
//   clr         : channel clear (level)
//   latch_en    : 1 = latched, 0 = auto-recover
//   signal_in   : raw asynchronous fault input
//   thr         : qualify threshold in ticks
//   fault       : qualified fault flag (registered)
//   fault_nxt   : value fault takes on the next edge (for first-fault capture)
module err_det_chan
    import err_det_pkg::*;
#(
    parameter int   CNT_W     = CNT_W_DEF,
    parameter logic POL       = 1'b0,
    parameter int   REC_TICKS = REC_TICKS_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             strobe,
    input  logic             reset_unit,
    input  logic             clr,
    input  logic             latch_en,
    input  logic             signal_in,
    input  logic [CNT_W-1:0] thr,
    output logic             fault,
    output logic             fault_nxt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] REC     = CNT_W'(REC_TICKS);

    logic [1:0]       sync;
    logic             act;
    logic             clear;
    logic             set_cond;
    logic [CNT_W-1:0] q;
    logic [CNT_W-1:0] r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync <= '0;
        else     sync <= {sync[0], signal_in};
    end

    assign act      = ~(sync[1] ^ POL);
    assign clear    = reset_unit | clr;
    // thr == 0 sets on the first active cycle, no tick needed
    assign set_cond = act & (q >= thr);

    always_comb begin
        fault_nxt = fault;
        if (clear)                       fault_nxt = 1'b0;
        else if (set_cond)               fault_nxt = 1'b1;
        else if (!latch_en && r >= REC)  fault_nxt = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          q <= '0;
        else if (clear || !act)           q <= '0;
        else if (strobe && q != CNT_MAX)  q <= q + 1'b1;
    end

    // Recovery only runs while a fault is held and the input is quiet;
    // it runs in latched mode too so a switch to auto resumes from here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          r <= '0;
        else if (clear || act || !fault)  r <= '0;
        else if (strobe && r != CNT_MAX)  r <= r + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) fault <= 1'b0;
        else     fault <= fault_nxt;
    end

endmodule

// File: rtl/multi_err_detect.sv
// Multi-channel fault-input qualifier.
//   clk, rst    : clock, async active-high reset
//   time_1us    : 1 us timebase (asynchronous to clk)
//   reset_unit  : clear all counters, faults and the first-fault record
//   clr         : per-channel fault clear
//   latch_en    : per-channel mode, 1 = latched
//   signal_in   : raw fault inputs
//   delay_tims  : packed per-channel thresholds, channel i at [i*CNT_W +: CNT_W]
//   fault       : qualified fault flags; fault_any = OR of them
//   first_id    : lowest channel of the first rising fault; first_vld marks it
module multi_err_detect
    import err_det_pkg::*;
#(
    parameter int            CH        = CH_DEF,
    parameter int            CNT_W     = CNT_W_DEF,
    parameter logic [CH-1:0] POL       = '0,
    parameter int            REC_TICKS = REC_TICKS_DEF,
    localparam int           ID_W      = clog2_min1(CH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                time_1us,
    input  logic                reset_unit,
    input  logic [CH-1:0]       clr,
    input  logic [CH-1:0]       latch_en,
    input  logic [CH-1:0]       signal_in,
    input  logic [CH*CNT_W-1:0] delay_tims,
    output logic [CH-1:0]       fault,
    output logic                fault_any,
    output logic [ID_W-1:0]     first_id,
    output logic                first_vld
);

    logic [1:0]    tsync;
    logic          strobe;
    logic [CH-1:0] fault_nxt;
    logic [CH-1:0] rise;
    logic [ID_W-1:0] low_id;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) tsync <= '0;
        else     tsync <= {tsync[0], time_1us};
    end

    // falling edge of the synchronised timebase
    assign strobe = tsync[1] & ~tsync[0];

    for (genvar i = 0; i < CH; i++) begin : g_ch
        err_det_chan #(
            .CNT_W     (CNT_W),
            .POL       (POL[i]),
            .REC_TICKS (REC_TICKS)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .strobe     (strobe),
            .reset_unit (reset_unit),
            .clr        (clr[i]),
            .latch_en   (latch_en[i]),
            .signal_in  (signal_in[i]),
            .thr        (delay_tims[i*CNT_W +: CNT_W]),
            .fault      (fault[i]),
            .fault_nxt  (fault_nxt[i])
        );
    end

    assign fault_any = |fault;
    assign rise      = fault_nxt & ~fault;

    // lowest rising index wins; scan high to low so the last hit is lowest
    always_comb begin
        low_id = '0;
        for (int i = CH - 1; i >= 0; i--) begin
            if (rise[i]) low_id = ID_W'(i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_id  <= '0;
            first_vld <= 1'b0;
        end else if (reset_unit) begin
            first_id  <= '0;
            first_vld <= 1'b0;
        end else if (!first_vld && |rise) begin
            first_id  <= low_id;
            first_vld <= 1'b1;
        end
    end

endmodule

// File: tb/tb_multi_err_detect.sv
module tb_multi_err_detect;

    localparam int            CH    = 8;
    localparam int            CNT_W = 14;
    localparam logic [CH-1:0] POL   = 8'h80;
    localparam int            REC   = 4;
    localparam int            ID_W  = 3;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                time_1us = 1'b0;
    logic                reset_unit = 1'b0;
    logic [CH-1:0]       clr = '0;
    logic [CH-1:0]       latch_en = '1;
    logic [CH-1:0]       signal_in = ~POL;
    logic [CH*CNT_W-1:0] delay_tims;
    logic [CH-1:0]       fault;
    logic                fault_any;
    logic [ID_W-1:0]     first_id;
    logic                first_vld;

    logic [CNT_W-1:0] thr_a [CH];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // reference model state: delayed input history and tick-count abstraction
    logic [CH-1:0]   h_sig [2];
    logic            h_tin [2];
    int              act_ticks  [CH];
    int              idle_ticks [CH];
    logic [CH-1:0]   m_fault;
    logic [ID_W-1:0] m_fid;
    logic            m_fvld;

    multi_err_detect #(.CH(CH), .CNT_W(CNT_W), .POL(POL), .REC_TICKS(REC)) dut (
        .clk(clk), .rst(rst), .time_1us(time_1us), .reset_unit(reset_unit),
        .clr(clr), .latch_en(latch_en), .signal_in(signal_in),
        .delay_tims(delay_tims), .fault(fault), .fault_any(fault_any),
        .first_id(first_id), .first_vld(first_vld)
    );

    always #5 clk = ~clk;

    always_comb begin
        delay_tims = '0;
        for (int i = 0; i < CH; i++) delay_tims[i*CNT_W +: CNT_W] = thr_a[i];
    end

    function automatic void model_reset();
        h_sig[0] = '0; h_sig[1] = '0;
        h_tin[0] = 1'b0; h_tin[1] = 1'b0;
        for (int i = 0; i < CH; i++) begin
            act_ticks[i] = 0; idle_ticks[i] = 0;
        end
        m_fault = '0; m_fid = '0; m_fvld = 1'b0;
    endfunction

    // One clock edge of behaviour. Inputs reach the logic two edges late;
    // a tick counts when the timebase seen two edges ago was high and one edge ago low.
    function automatic void model_edge();
        logic          tick;
        logic          act, clear, set;
        logic [CH-1:0] nf, rise;
        bit            found;
        if (rst) begin model_reset(); return; end
        tick = h_tin[1] & ~h_tin[0];
        for (int i = 0; i < CH; i++) begin
            act   = (h_sig[1][i] == POL[i]);
            clear = reset_unit | clr[i];
            set   = act && (act_ticks[i] >= int'(thr_a[i]));
            if (clear)                                       nf[i] = 1'b0;
            else if (set)                                    nf[i] = 1'b1;
            else if (!latch_en[i] && idle_ticks[i] >= REC)   nf[i] = 1'b0;
            else                                             nf[i] = m_fault[i];
            if (clear || act || !m_fault[i]) idle_ticks[i] = 0;
            else if (tick)                   idle_ticks[i]++;
            if (clear || !act) act_ticks[i] = 0;
            else if (tick)     act_ticks[i]++;
        end
        rise = nf & ~m_fault;
        if (reset_unit) begin
            m_fvld = 1'b0; m_fid = '0;
        end else if (!m_fvld && rise != '0) begin
            found = 0;
            for (int i = 0; i < CH; i++)
                if (rise[i] && !found) begin m_fid = ID_W'(i); found = 1; end
            m_fvld = 1'b1;
        end
        m_fault  = nf;
        h_sig[1] = h_sig[0]; h_sig[0] = signal_in;
        h_tin[1] = h_tin[0]; h_tin[0] = time_1us;
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc++;
        time_1us = (cyc % 3 == 0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) step();
        checks++;
        if ({fault, fault_any, first_vld, first_id} !== '0) begin
            errors++;
            $display("FAIL reset_state got=%h/%b/%b/%0d exp=0", fault, fault_any, first_vld, first_id);
        end
        rst = 1'b0;
        repeat (6) begin
            step();
            checks++;
            if ({fault, fault_any, first_vld, first_id} !== {m_fault, |m_fault, m_fvld, m_fid}) begin
                errors++;
                $display("FAIL reset_release got=%h/%b exp=%h/%b", fault, first_vld, m_fault, m_fvld);
            end
        end
    endtask

    task automatic test_threshold();
        int n;
        thr_a[3] = 5; latch_en[3] = 1'b1;
        signal_in[3] = 1'b0;
        n = 0;
        while (act_ticks[3] < 5 && n < 100) begin step(); n++; end
        checks++;
        if (n >= 100) begin errors++; $display("FAIL thr_wait timeout"); end
        checks++;
        if (fault[3] !== 1'b0) begin errors++; $display("FAIL thr_early got=%b exp=0", fault[3]); end
        step();
        checks++;
        if ({fault[3], first_vld, first_id} !== {1'b1, 1'b1, 3'd3}) begin
            errors++;
            $display("FAIL thr_set got=%b/%b/%0d exp=1/1/3", fault[3], first_vld, first_id);
        end
        signal_in[3] = 1'b1;
        repeat (3) step();
        clr[3] = 1'b1; step(); clr[3] = 1'b0;
        checks++;
        if (fault[3] !== 1'b0) begin errors++; $display("FAIL thr_clr got=%b exp=0", fault[3]); end
        // 4-tick pulse must not qualify
        signal_in[3] = 1'b0;
        n = 0;
        while (act_ticks[3] < 4 && n < 100) begin step(); n++; end
        signal_in[3] = 1'b1;
        repeat (10) begin
            step();
            checks++;
            if (fault[3] !== 1'b0) begin errors++; $display("FAIL thr_short got=%b exp=0", fault[3]); end
        end
    endtask

    task automatic test_auto_recover();
        int n;
        thr_a[2] = 2; latch_en[2] = 1'b0;
        signal_in[2] = 1'b0;
        n = 0;
        while (!m_fault[2] && n < 100) begin step(); n++; end
        checks++;
        if (fault[2] !== 1'b1) begin errors++; $display("FAIL auto_set got=%b exp=1", fault[2]); end
        signal_in[2] = 1'b1;
        n = 0;
        while (idle_ticks[2] < 4 && n < 100) begin step(); n++; end
        checks++;
        if (fault[2] !== 1'b1) begin errors++; $display("FAIL auto_hold got=%b exp=1", fault[2]); end
        step();
        checks++;
        if (fault[2] !== 1'b0) begin errors++; $display("FAIL auto_clear got=%b exp=0", fault[2]); end
        // reassert after 3 quiet ticks: fault must not drop
        signal_in[2] = 1'b0;
        n = 0;
        while (!m_fault[2] && n < 100) begin step(); n++; end
        signal_in[2] = 1'b1;
        n = 0;
        while (idle_ticks[2] < 3 && n < 100) begin step(); n++; end
        signal_in[2] = 1'b0;
        repeat (20) begin
            step();
            checks++;
            if (fault[2] !== 1'b1) begin errors++; $display("FAIL auto_reassert got=%b exp=1", fault[2]); end
        end
        signal_in[2] = 1'b1;
        repeat (30) step();
        checks++;
        if (fault[2] !== 1'b0) begin errors++; $display("FAIL auto_final got=%b exp=0", fault[2]); end
        latch_en[2] = 1'b1;
    endtask

    task automatic test_latched_clr();
        int n;
        thr_a[4] = 1; latch_en[4] = 1'b1;
        signal_in[4] = 1'b0;
        n = 0;
        while (!m_fault[4] && n < 100) begin step(); n++; end
        signal_in[4] = 1'b1;
        repeat (12) begin
            step();
            checks++;
            if (fault[4] !== 1'b1) begin errors++; $display("FAIL latch_hold got=%b exp=1", fault[4]); end
        end
        clr[4] = 1'b1; step(); clr[4] = 1'b0;
        checks++;
        if (fault[4] !== 1'b0) begin errors++; $display("FAIL latch_clr got=%b exp=0", fault[4]); end
        // clr against a standing set condition
        thr_a[4] = 0; signal_in[4] = 1'b0;
        repeat (4) step();
        clr[4] = 1'b1; step(); clr[4] = 1'b0;
        checks++;
        if (fault[4] !== 1'b0) begin errors++; $display("FAIL clr_wins got=%b exp=0", fault[4]); end
        step();
        checks++;
        if (fault[4] !== 1'b1) begin errors++; $display("FAIL clr_reset got=%b exp=1", fault[4]); end
        signal_in[4] = 1'b1;
        repeat (3) step();
        clr[4] = 1'b1; step(); clr[4] = 1'b0;
    endtask

    task automatic test_first_fault();
        int n;
        reset_unit = 1'b1; step(); reset_unit = 1'b0;
        checks++;
        if ({fault, first_vld} !== '0) begin errors++; $display("FAIL ff_clear got=%h/%b exp=0", fault, first_vld); end
        thr_a[5] = 3; thr_a[1] = 3;
        signal_in[5] = 1'b0; signal_in[1] = 1'b0;
        n = 0;
        while (!m_fault[1] && n < 100) begin step(); n++; end
        checks++;
        if ({fault[5], fault[1], first_vld, first_id} !== {1'b1, 1'b1, 1'b1, 3'd1}) begin
            errors++;
            $display("FAIL ff_simul got=%b%b/%b/%0d exp=11/1/1", fault[5], fault[1], first_vld, first_id);
        end
        thr_a[0] = 0; signal_in[0] = 1'b0;
        repeat (4) step();
        checks++;
        if ({fault[0], first_id} !== {1'b1, 3'd1}) begin
            errors++;
            $display("FAIL ff_later got=%b/%0d exp=1/1", fault[0], first_id);
        end
        reset_unit = 1'b1; step(); reset_unit = 1'b0;
        checks++;
        if ({fault, first_vld} !== '0) begin errors++; $display("FAIL ff_unit got=%h/%b exp=0", fault, first_vld); end
        signal_in[0] = 1'b1; signal_in[1] = 1'b1; signal_in[5] = 1'b1;
        repeat (3) step();
        reset_unit = 1'b1; step(); reset_unit = 1'b0;
    endtask

    task automatic test_boundary_thr0();
        thr_a[6] = 0; signal_in[6] = 1'b0;
        repeat (2) begin
            step();
            checks++;
            if (fault[6] !== 1'b0) begin errors++; $display("FAIL thr0_early got=%b exp=0", fault[6]); end
        end
        step();
        checks++;
        if (fault[6] !== 1'b1) begin errors++; $display("FAIL thr0_edge3 got=%b exp=1", fault[6]); end
        // active-high channel, same latency
        thr_a[7] = 0; signal_in[7] = 1'b1;
        repeat (2) begin
            step();
            checks++;
            if (fault[7] !== 1'b0) begin errors++; $display("FAIL pol_thr0_early got=%b exp=0", fault[7]); end
        end
        step();
        checks++;
        if (fault[7] !== 1'b1) begin errors++; $display("FAIL pol_thr0_edge3 got=%b exp=1", fault[7]); end
        signal_in[6] = 1'b1; signal_in[7] = 1'b0;
        repeat (3) step();
        reset_unit = 1'b1; step(); reset_unit = 1'b0;
    endtask

    task automatic test_pol_high();
        thr_a[7] = 0; latch_en[7] = 1'b0; signal_in[7] = 1'b0;
        repeat (10) begin
            step();
            checks++;
            if (fault[7] !== 1'b0) begin errors++; $display("FAIL pol_inactive got=%b exp=0", fault[7]); end
        end
        thr_a[7] = 4; signal_in[7] = 1'b1;
        repeat (25) begin
            step();
            checks++;
            if (fault !== m_fault) begin errors++; $display("FAIL pol_qualify got=%h exp=%h", fault, m_fault); end
        end
        signal_in[7] = 1'b0;
        repeat (25) begin
            step();
            checks++;
            if (fault !== m_fault) begin errors++; $display("FAIL pol_recover got=%h exp=%h", fault, m_fault); end
        end
        checks++;
        if (fault[7] !== 1'b0) begin errors++; $display("FAIL pol_final got=%b exp=0", fault[7]); end
        latch_en[7] = 1'b1;
    endtask

    task automatic test_saturate();
        int n, rises;
        logic prev;
        thr_a[3] = 14'd16383; latch_en[3] = 1'b1;
        signal_in[3] = 1'b0;
        rises = 0; prev = fault[3]; n = 0;
        while (act_ticks[3] < 16400 && n < 16400 * 3 + 50) begin
            step(); n++;
            checks++;
            if (fault[3] !== m_fault[3]) begin
                errors++;
                $display("FAIL sat_track cyc=%0d got=%b exp=%b", cyc, fault[3], m_fault[3]);
            end
            if (fault[3] && !prev) rises++;
            prev = fault[3];
        end
        checks++;
        if ({rises, fault[3]} !== {32'd1, 1'b1}) begin
            errors++;
            $display("FAIL sat_once rises=%0d fault=%b exp=1/1", rises, fault[3]);
        end
        signal_in[3] = 1'b1;
        repeat (3) step();
        reset_unit = 1'b1; step(); reset_unit = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < CH; i++) begin
            thr_a[i]    = CNT_W'($urandom_range(0, 5));
            latch_en[i] = 1'($urandom_range(0, 1));
        end
        repeat (1500) begin
            for (int i = 0; i < CH; i++) begin
                if ($urandom_range(0, 7) == 0) signal_in[i] = ~signal_in[i];
                clr[i] = ($urandom_range(0, 39) == 0);
                if ($urandom_range(0, 99) == 0) latch_en[i] = ~latch_en[i];
            end
            reset_unit = ($urandom_range(0, 199) == 0);
            step();
            checks++;
            if ({fault, fault_any, first_vld, first_id} !== {m_fault, |m_fault, m_fvld, m_fid}) begin
                errors++;
                $display("FAIL random cyc=%0d got=%h/%b/%b/%0d exp=%h/%b/%b/%0d", cyc,
                         fault, fault_any, first_vld, first_id, m_fault, |m_fault, m_fvld, m_fid);
            end
        end
        clr = '0; reset_unit = 1'b0; signal_in = ~POL; latch_en = '1;
        repeat (3) step();
    endtask

    task automatic test_reset_mid();
        int n;
        reset_unit = 1'b1; step(); reset_unit = 1'b0;
        thr_a[3] = 10; thr_a[6] = 0;
        signal_in[3] = 1'b0; signal_in[6] = 1'b0;
        n = 0;
        while (act_ticks[3] < 4 && n < 100) begin step(); n++; end
        checks++;
        if (fault[6] !== 1'b1) begin errors++; $display("FAIL mid_pre got=%b exp=1", fault[6]); end
        #2 rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if ({fault, fault_any, first_vld, first_id} !== '0) begin
            errors++;
            $display("FAIL mid_async got=%h/%b/%b/%0d exp=0", fault, fault_any, first_vld, first_id);
        end
        repeat (2) step();
        rst = 1'b0;
        n = 0;
        while (!m_fault[3] && n < 200) begin
            step(); n++;
            checks++;
            if ({fault, fault_any, first_vld, first_id} !== {m_fault, |m_fault, m_fvld, m_fid}) begin
                errors++;
                $display("FAIL mid_restart cyc=%0d got=%h/%b/%0d exp=%h/%b/%0d", cyc,
                         fault, first_vld, first_id, m_fault, m_fvld, m_fid);
            end
        end
        checks++;
        if (fault[3] !== 1'b1) begin errors++; $display("FAIL mid_requal got=%b exp=1", fault[3]); end
    endtask

    initial begin
        for (int i = 0; i < CH; i++) thr_a[i] = 20;
        model_reset();
        test_reset();
        test_threshold();
        test_auto_recover();
        test_latched_clr();
        test_first_fault();
        test_boundary_thr0();
        test_pol_high();
        test_saturate();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multi_err_detect.md
# multi_err_detect

Multi-channel fault-input qualifier for the power unit. Replaces per-signal single-channel low-level detectors: each of CH fault lines is synchronised, polarity-normalised, and qualified against its own microsecond threshold. Each channel is then latched or auto-recovered with hysteresis. A first-fault record feeds the protection/shutdown logic and status readback.

## Interface
Parameters:
- CH, 8, number of fault channels (1..32)
- CNT_W, 14, width of qualify counters and thresholds
- POL, {CH{1'b0}}, per-channel active level; bit=0 means fault active-low, bit=1 means fault active-high
- REC_TICKS, 4, inactive 1 µs ticks required before an auto-mode fault clears (1..2^CNT_W-1)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- time_1us  in  1  1 µs timebase from the timer block; may be skewed, so it is synchronised internally
- reset_unit  in  1  global clear of all counters, faults and the first-fault record
- clr  in  CH  per-channel fault clear, level-sensitive
- latch_en  in  CH  per-channel mode; 1 = latched, 0 = auto-recover
- signal_in  in  CH  raw fault inputs, asynchronous
- delay_tims  in  CH*CNT_W  per-channel qualify threshold in µs; channel i uses bits [i*CNT_W +: CNT_W]
- fault  out  CH  qualified fault flags
- fault_any  out  1  OR of fault
- first_id  out  $clog2(CH) (min 1)  index of the first channel to fault
- first_vld  out  1  first_id valid

## Operation
- Tick strobe: time_1us passes through a 2-flop synchroniser. The strobe is a 1-cycle pulse on the synchronised falling edge (sync pair = 2'b10).
- Input path: each signal_in bit passes through a 2-flop synchroniser. act[i] = sync[i] XNOR POL[i].
- Qualify counter q[i]:
  - Cleared on reset_unit, on clr[i], or when !act[i].
  - Otherwise increments on strobe.
  - Saturates at 2^CNT_W-1; no wrap.
- Set condition: act[i] && q[i] >= thr[i]. With thr = 0 the fault sets on the first active cycle, without waiting for a tick. An inactive input never sets a fault, whatever thr is.
- Recovery counter r[i]:
  - Cleared when act[i], when fault[i]=0, or on any clear.
  - Otherwise increments on strobe, saturating.
- Auto mode (latch_en[i]=0): fault[i] clears when r[i] reaches REC_TICKS. A fault that reasserts before that count keeps fault[i] set and restarts r.
- Latched mode: fault[i] clears only on clr[i] or reset_unit. latch_en is sampled every cycle, so switching to auto while latched starts recovery from the current r.
- Priority per channel: rst > reset_unit > clr[i] > set > auto-recover clear.
- First-fault record: when first_vld=0 and one or more fault bits rise in the same cycle, the lowest rising index is stored and first_vld is set. The record holds until reset_unit. clr does not touch it.

## Timing
- Reset values: fault=0, fault_any=0, first_id=0, first_vld=0, all counters 0, all sync flops 0.
  - The input sync flops reset to 0. For an active-low channel this reads as active for 2 cycles after reset.
  - Any fault-set during that window is allowed, and the bench must account for it.
- Input edge to act[i]: 2 clk cycles.
- thr=0: fault high 1 clk after act[i] rises, so 3 clk after the signal_in edge.
- thr=N (N>0): fault high 1 clk after the N-th strobe counted while act[i] stays continuously active.
- fault_any is combinational from the fault register. first_id and first_vld update on the same edge as the fault bit that causes them.
- clr[i] or reset_unit asserted in the same cycle as a set condition: the clear wins. The fault sets again on the next cycle only if the set condition still holds after the counter restarts from 0.
- Asynchronous rst mid-count returns all state to reset values immediately.

## Structure
- Package err_det_pkg holds the default constants (CH_DEF, CNT_W_DEF, REC_TICKS_DEF) and the function clog2_min1.
- Sub-module err_det_chan holds one channel: input synchroniser, q and r counters, and the fault flag. It is generate-instantiated CH times.
- The top level holds the shared tick synchroniser and edge detect, the fault_any OR, and the first-fault priority encoder.

## Test plan
- Threshold qualify: CH=8, POL=0, delay_tims[ch3]=5, latch_en=1. Hold signal_in[3]=0.
  - Required: fault[3] rises 1 clk after the 5th strobe, first_id=3, first_vld=1.
  - Release and retest with a 4-tick pulse: no fault.
- Auto-recover: latch_en[2]=0, thr=2, REC_TICKS=4. Fault ch2, then deassert the input.
  - Required: fault[2] clears 1 clk after the 4th inactive strobe.
  - A reassertion after 3 inactive ticks keeps the fault set.
- Latched and clear: a fault in latched mode persists after the input is released, until a 1-cycle clr[i] pulse.
  - clr coinciding with a set condition leaves fault=0 on that edge.
- Simultaneous first fault: ch5 and ch1 qualify on the same cycle.
  - Required: first_id=1. A later ch0 fault does not change the record. reset_unit clears first_vld.
- Boundaries: thr=0 with an active input gives a fault 3 clk after the input edge.
  - thr=16383 with the input held 16400 ticks: the counter saturates without wrapping, and the fault asserts once.
  - POL=1 channel: active-high behaviour mirrors the above.
- Reset mid-operation: assert rst while counters are non-zero and fault=1. All outputs go to 0 asynchronously, and after release qualification restarts from 0.
